// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder that adds one CHUNK-bit slice per clock, LSB first.
// Optional subtract mode via SEQ_ADDER_SUB_EN (adds port sub; sub=1 computes a - b).
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b;
  logic             sub_sel;
  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

`ifdef SEQ_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign a_chunk   = op_a[idx*CHUNK +: CHUNK];
  assign b_chunk   = op_b[idx*CHUNK +: CHUNK];
  assign chunk_sum = add_chunk(a_chunk, b_chunk, carry);
  // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ cin.
  assign msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  assign accept    = in_valid && in_ready;
  assign last      = (state == BUSY) && (idx == LAST);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: if (idx == LAST) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Slice accumulation: one chunk per BUSY cycle, flags captured on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= sub_sel ? 1'b1 : ci;
    end else if (state == BUSY) begin
      s[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry <= chunk_sum[CHUNK];
      if (last) begin
        idx <= '0;
        co  <= chunk_sum[CHUNK];
        ovf <= msb_cin ^ chunk_sum[CHUNK];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Operands are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= a;
      op_b <= sub_sel ? ~b : b;
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: a 16/4 instance and a 16/16 (single-chunk) instance,
// checked against an arithmetic reference model. Sub tests run when SEQ_ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        ci = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_ready = 1'b1;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [15:0] s0, s1;
  logic        co0, co1, ovf0, ovf1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_q[$];
  logic [17:0] res_q[$];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .ci(ci),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid0), .out_ready(out_ready), .s(s0), .co(co0), .ovf(ovf0));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .ci(ci),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .s(s1), .co(co1), .ovf(ovf1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid0 && in_ready0) acc_q.push_back(cyc);
    if (out_valid0 && out_ready) res_q.push_back({s0, co0, ovf0});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: true integer sum/difference, then wrap and range checks.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin, input logic sb);
    longint ux, uy, sx, sy, us, ss;
    logic [15:0] r;
    logic c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      us = ux - uy + 65536;
      ss = sx - sy;
    end else begin
      us = ux + uy + longint'(cin);
      ss = sx + sy + longint'(cin);
    end
    r = us[15:0];
    c = (us >= 65536);
    v = (ss > 32767) || (ss < -32768);
    return {r, c, v};
  endfunction

  function automatic logic rdy(input int which);
    return (which == 0) ? in_ready0 : in_ready1;
  endfunction

  function automatic logic ov(input int which);
    return (which == 0) ? out_valid0 : out_valid1;
  endfunction

  task automatic run_op(input int which, input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input logic subv,
                        output int lat, output logic [17:0] got);
    int n;
    @(negedge clk);
    a = av; b = bv; ci = civ;
`ifdef SEQ_ADDER_SUB_EN
    sub = subv;
`endif
    n = 0;
    while (!rdy(which) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rdy(which) !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_wait dut%0d: got %b want 1", which, rdy(which));
    end
    if (which == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid0 = 1'b0; in_valid1 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!ov(which) && lat < 50);
    got = (which == 0) ? {s0, co0, ovf0} : {s1, co1, ovf1};
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({s0, co0, ovf0, out_valid0, in_ready0} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_dut0: got s=%h co=%b ovf=%b ov=%b ir=%b want 0 0 0 0 1",
               s0, co0, ovf0, out_valid0, in_ready0);
    end
    tests++;
    if ({s1, co1, ovf1, out_valid1, in_ready1} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_dut1: got s=%h co=%b ovf=%b ov=%b ir=%b want 0 0 0 0 1",
               s1, co1, ovf1, out_valid1, in_ready1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta[3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [15:0] tb[3] = '{16'h4321, 16'h0001, 16'h0000};
    logic        tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] te[3] = '{{16'h5555, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1}};
    int lat;
    logic [17:0] got;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 3; i++) begin
        run_op(w, ta[i], tb[i], tc[i], 1'b0, lat, got);
        tests++;
        if (got !== te[i]) begin
          fails++;
          $display("FAIL directed%0d_dut%0d: got {s,co,ovf}=%h want %h", i, w, got, te[i]);
        end
        tests++;
        if (lat != ((w == 0) ? 4 : 1)) begin
          fails++;
          $display("FAIL latency%0d_dut%0d: got %0d want %0d", i, w, lat, (w == 0) ? 4 : 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [17:0] got, exp;
    logic [15:0] av, bv;
    logic civ, subv;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      civ = 1'($urandom);
      subv = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      subv = 1'($urandom);
`endif
      run_op(i % 2, av, bv, civ, subv, lat, got);
      exp = model(av, bv, civ, subv);
      tests++;
      if (got !== exp || lat != ((i % 2 == 0) ? 4 : 1)) begin
        fails++;
        $display("FAIL random%0d: a=%h b=%h ci=%b sub=%b got %h lat %0d want %h lat %0d",
                 i, av, bv, civ, subv, got, lat, exp, (i % 2 == 0) ? 4 : 1);
      end
    end
  endtask

  task automatic test_stall();
    int lat, nacc;
    logic [17:0] got, exp;
    logic [15:0] av, bv;
    av = 16'($urandom);
    bv = 16'($urandom);
    exp = model(av, bv, 1'b1, 1'b0);
    out_ready = 1'b0;
    run_op(0, av, bv, 1'b1, 1'b0, lat, got);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL stall_result: got %h want %h", got, exp);
    end
    nacc = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      in_valid0 = 1'b1;
      tests++;
      if ({s0, co0, ovf0, out_valid0, in_ready0} !== {exp, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold%0d: got s=%h co=%b ovf=%b ov=%b ir=%b want %h ov=1 ir=0",
                 i, s0, co0, ovf0, out_valid0, in_ready0, exp);
      end
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    tests++;
    if (acc_q.size() != nacc) begin
      fails++;
      $display("FAIL stall_no_accept: got %0d accepts want %0d", acc_q.size(), nacc);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: got ov=%b ir=%b want 0 1", out_valid0, in_ready0);
    end
  endtask

  task automatic test_reset_busy();
    int lat, n;
    logic [17:0] got;
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; ci = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    n = 0;
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid0 = 1'b1;
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (s0[7:0] !== 8'h22 || out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL partial_chunks: got s[7:0]=%h ov=%b want 22 0", s0[7:0], out_valid0);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s0, co0, ovf0, out_valid0, in_ready0} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_busy: got s=%h co=%b ovf=%b ov=%b ir=%b want 0 0 0 0 1",
               s0, co0, ovf0, out_valid0, in_ready0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'h0001, 16'h0001, 1'b1, 1'b0, lat, got);
    tests++;
    if (got !== {16'h0003, 1'b0, 1'b0} || lat != 4) begin
      fails++;
      $display("FAIL after_reset: got %h lat %0d want %h lat 4", got, lat, {16'h0003, 2'b00});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] av, bv;
    logic civ;
    logic [17:0] exp;
    av = 16'($urandom);
    bv = 16'($urandom);
    civ = 1'($urandom);
    exp = model(av, bv, civ, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    a = av; b = bv; ci = civ;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    n = 0;
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_q.delete();
    res_q.delete();
    in_valid0 = 1'b1;
    repeat (20) @(posedge clk);
    #1 in_valid0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (acc_q.size() != 4) begin
      fails++;
      $display("FAIL b2b_accepts: got %0d want 4", acc_q.size());
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      tests++;
      if (acc_q[i] - acc_q[i-1] != 6) begin
        fails++;
        $display("FAIL b2b_interval%0d: got %0d want 6", i, acc_q[i] - acc_q[i-1]);
      end
    end
    tests++;
    if (res_q.size() != 4) begin
      fails++;
      $display("FAIL b2b_results: got %0d want 4", res_q.size());
    end
    for (int i = 0; i < res_q.size(); i++) begin
      tests++;
      if (res_q[i] !== exp) begin
        fails++;
        $display("FAIL b2b_value%0d: got %h want %h", i, res_q[i], exp);
      end
    end
  endtask

`ifdef SEQ_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    logic [17:0] got;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      run_op(w, 16'h0005, 16'h0007, 1'b0, 1'b1, lat, got);
      tests++;
      if (got !== {16'hFFFE, 1'b0, 1'b0} || lat != ((w == 0) ? 4 : 1)) begin
        fails++;
        $display("FAIL sub_dut%0d: got %h lat %0d want %h lat %0d",
                 w, got, lat, {16'hFFFE, 2'b00}, (w == 0) ? 4 : 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_busy();
    test_back_to_back();
`ifdef SEQ_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
